// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART types and constants (receiver and transmitter)
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    // 50 MHz / 115200 baud
    localparam int UART_CLKS_PER_BIT_DEFAULT = 434;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_rx_state_t;

    // Width of a cycle counter that spans 0..clks-1.
    function automatic int uart_cnt_width(input int clks);
        return (clks > 2) ? $clog2(clks) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_if.sv
// ============================================================================
// uart_rx_if : serial line, byte handshake and status of the UART receiver
// Rev 1.0
// ============================================================================
`default_nettype none

interface uart_rx_if;

    logic       rx;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    // master: line driver and byte consumer; slave: the receiver itself
    modport master (
        output rx,
        output rx_ack,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        input  busy
    );

    modport slave (
        input  rx,
        input  rx_ack,
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        output busy
    );

endinterface

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// sync_2ff : two-flop synchronizer for asynchronous single-bit inputs
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_async,
    output logic      o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// uart_rx : 8N1 UART receiver with one-entry holding register and status
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  wire logic clk,
    input  wire logic rst,
    uart_rx_if.slave  bus
);

    localparam int                 c_CNT_W = uart_cnt_width(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_HALF  = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);

    uart_rx_state_t     r_state;
    uart_rx_state_t     w_state_next;
    logic [c_CNT_W-1:0] r_cycle_cnt;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic [7:0]         r_data;
    logic               r_valid;
    logic               r_frame_err;
    logic               r_overrun;

    logic               w_rxs;
    logic               w_cnt_clr;
    logic               w_cnt_run;
    logic               w_bit_clr;
    logic               w_shift_en;
    logic               w_load;
    logic               w_frame_err;
    logic               w_ack_take;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.rx),
        .o_sync  (w_rxs)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_clr    = 1'b0;
        w_cnt_run    = 1'b0;
        w_bit_clr    = 1'b0;
        w_shift_en   = 1'b0;
        w_load       = 1'b0;
        w_frame_err  = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_clr = 1'b1;
                w_bit_clr = 1'b1;
                if (!w_rxs) begin
                    w_state_next = START;
                end
            end
            START: begin
                w_cnt_run = 1'b1;
                // A start bit that is gone by mid-bit is treated as a glitch.
                if (r_cycle_cnt == c_HALF) begin
                    w_cnt_clr    = 1'b1;
                    w_state_next = w_rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                w_cnt_run = 1'b1;
                if (r_cycle_cnt == c_LAST) begin
                    w_cnt_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = STOP;
                    end
                end
            end
            STOP: begin
                w_cnt_run = 1'b1;
                // Leaving at mid stop bit leaves half a bit to catch the next start edge.
                if (r_cycle_cnt == c_LAST) begin
                    w_cnt_clr = 1'b1;
                    if (w_rxs) begin
                        w_load       = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_frame_err  = 1'b1;
                        w_state_next = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                w_cnt_clr = 1'b1;
                if (w_rxs) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_cnt_clr    = 1'b1;
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cycle_cnt <= '0;
        end else if (w_cnt_run) begin
            r_cycle_cnt <= r_cycle_cnt + c_CNT_W'(1);
        end
    end

    // The bit counter wraps 7 -> 0 on the last data sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            if (w_bit_clr) begin
                r_bit_cnt <= 3'd0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_shift_en) begin
                r_shift <= {w_rxs, r_shift[7:1]};
            end
        end
    end

    assign w_ack_take = bus.rx_ack & r_valid;

    // An ack in the same cycle as a load consumes the old byte, so no overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                if (r_valid && !bus.rx_ack) begin
                    r_overrun <= 1'b1;
                end else if (w_ack_take) begin
                    r_overrun <= 1'b0;
                end
            end else if (w_ack_take) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.rx_data   = r_data;
    assign bus.rx_valid  = r_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;
    assign bus.busy      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// tb_uart_rx : directed and randomized frames against a byte-level receiver model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx;

    localparam int CPB = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_rx_if bus ();

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    int ferr_seen = 0;

    // Model of the holding register as seen by the consumer.
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ovr;

    always @(negedge clk) begin
        if (bus.frame_err === 1'b1) ferr_seen++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic b, input int n);
        bus.rx = b;
        tick(n);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_cycles);
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(b[i], CPB);
        drive(stop_bit, stop_cycles);
    endtask

    task automatic ack();
        bus.rx_ack = 1'b1;
        tick(1);
        bus.rx_ack = 1'b0;
    endtask

    task automatic m_reset();
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic m_ack();
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    task automatic m_load(input logic [7:0] b, input logic acked);
        if (m_valid && !acked) m_ovr = 1'b1;
        else if (m_valid && acked) m_ovr = 1'b0;
        m_data  = b;
        m_valid = 1'b1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_data"},  32'(bus.rx_data),  32'(m_data));
        check({tag, "_valid"}, 32'(bus.rx_valid), 32'(m_valid));
        check({tag, "_ovr"},   32'(bus.overrun),  32'(m_ovr));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},  32'(bus.rx_data),   32'h0);
        check({tag, "_valid"}, 32'(bus.rx_valid),  32'h0);
        check({tag, "_ferr"},  32'(bus.frame_err), 32'h0);
        check({tag, "_ovr"},   32'(bus.overrun),   32'h0);
        check({tag, "_busy"},  32'(bus.busy),      32'h0);
    endtask

    int         ferr_before;
    int         waited;
    int         gap;
    logic       saw_busy;
    logic [7:0] rb;

    initial begin
        rst        = 1'b1;
        bus.rx     = 1'b1;
        bus.rx_ack = 1'b0;
        m_reset();
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        tick(2);

        // Single byte and handshake
        send_frame(8'h55, 1'b1, CPB);
        m_load(8'h55, 1'b0);
        check_model("b55");
        check("b55_ferr", 32'(ferr_seen), 32'd0);
        ack();
        m_ack();
        check("b55_acked_valid", 32'(bus.rx_valid), 32'd0);

        // Back-to-back frames, acking the first while the second starts
        send_frame(8'hA3, 1'b1, CPB);
        m_load(8'hA3, 1'b0);
        check_model("bA3");
        fork
            send_frame(8'h0F, 1'b1, CPB);
            ack();
        join
        m_ack();
        m_load(8'h0F, 1'b0);
        check_model("b0F");
        ack();
        m_ack();
        check("b2b_ferr", 32'(ferr_seen), 32'd0);

        // Framing error followed by a long break
        ferr_before = ferr_seen;
        send_frame(8'h3C, 1'b0, CPB);
        check("ferr_pulse", 32'(ferr_seen), 32'(ferr_before + 1));
        check("ferr_busy", 32'(bus.busy), 32'd1);
        drive(1'b0, 19 * CPB);
        check("break_ferr", 32'(ferr_seen), 32'(ferr_before + 1));
        check("break_busy", 32'(bus.busy), 32'd1);
        check_model("break");
        drive(1'b1, 2 * CPB);
        check("break_end_busy", 32'(bus.busy), 32'd0);
        send_frame(8'h81, 1'b1, CPB);
        m_load(8'h81, 1'b0);
        check_model("b81");
        ack();
        m_ack();

        // Overrun
        send_frame(8'h11, 1'b1, CPB);
        m_load(8'h11, 1'b0);
        check_model("b11");
        send_frame(8'h22, 1'b1, CPB);
        m_load(8'h22, 1'b0);
        check_model("b22_ovr");
        ack();
        m_ack();
        check_model("ovr_acked");
        ack();
        m_ack();
        check_model("ack_idle");

        // Load and ack on the same edge
        send_frame(8'h44, 1'b1, CPB);
        m_load(8'h44, 1'b0);
        check_model("b44");
        fork
            send_frame(8'h5A, 1'b1, CPB);
            begin
                tick(78);
                bus.rx_ack = 1'b1;
                tick(1);
                bus.rx_ack = 1'b0;
            end
        join
        m_load(8'h5A, 1'b1);
        check_model("same_edge");

        // Short low glitch on an idle line
        ferr_before = ferr_seen;
        drive(1'b0, 2);
        bus.rx   = 1'b1;
        waited   = 0;
        saw_busy = 1'b0;
        while (bus.busy !== 1'b0 || (!saw_busy && waited < 4)) begin
            if (bus.busy === 1'b1) saw_busy = 1'b1;
            if (waited >= CPB / 2 + 2) break;
            tick(1);
            waited++;
        end
        check("glitch_busy_seen", 32'(saw_busy), 32'd1);
        check("glitch_busy_back", 32'(bus.busy), 32'd0);
        check("glitch_ferr", 32'(ferr_seen), 32'(ferr_before));
        check_model("glitch");

        // Reset in the middle of data bit 4
        fork
            send_frame(8'hF0, 1'b1, CPB);
            begin
                tick(5 * CPB + 3);
                rst = 1'b1;
                tick(1);
                check_all_zero("midrst");
                rst = 1'b0;
            end
        join
        m_reset();
        tick(CPB);
        check_model("rst_lost");
        check("rst_idle_busy", 32'(bus.busy), 32'd0);
        send_frame(8'h7E, 1'b1, CPB);
        m_load(8'h7E, 1'b0);
        check_model("b7E");

        // Random bytes, random gaps, random acking
        for (int i = 0; i < 12; i++) begin
            rb = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                ack();
                m_ack();
            end
            gap = $urandom_range(0, CPB);
            if (gap > 0) drive(1'b1, gap);
            send_frame(rb, 1'b1, CPB);
            m_load(rb, 1'b0);
            check_model($sformatf("rnd%0d", i));
        end
        check("rnd_ferr", 32'(ferr_seen), 32'(ferr_before));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
